// File: rtl/addac_pkg.sv
// Shared types and helpers for the slice-serial add/accumulate unit.
package addac_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic inv;
        logic acc_en;
        logic cin;
    } op_cfg_t;

    localparam int MAX_W = 64;

    function automatic int slice_count(input int width, input int slice_w);
        return width / slice_w;
    endfunction

    // Most-negative (neg=1) or most-positive (neg=0) signed value of the given width.
    function automatic logic [MAX_W-1:0] sat_limit(input int width, input logic neg);
        logic [MAX_W-1:0] msb;
        msb = MAX_W'(1) << (width - 1);
        return neg ? msb : (msb - MAX_W'(1));
    endfunction

endpackage

// File: rtl/addac_serial_adder_slice.sv
// SLICE_W-bit combinational ripple adder, reused once per slice by the top.
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};

endmodule

// File: rtl/addac_serial.sv
// Slice-serial invert/add/accumulate unit: WIDTH-bit operands processed SLICE_W bits
// per clock, LSB first, with a registered carry and optional signed saturation.
module addac_serial
    import addac_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SLICE_W = 4,
    parameter bit SAT     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic             inv,
    input  logic             acc_en,
    input  logic             cin,
    input  logic             clr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = slice_count(WIDTH, SLICE_W);
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
    localparam logic [WIDTH-1:0] SAT_POS  = WIDTH'(sat_limit(WIDTH, 1'b0));
    localparam logic [WIDTH-1:0] SAT_NEG  = WIDTH'(sat_limit(WIDTH, 1'b1));

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_a, r_shadow, r_s;
    logic               r_inv, r_acc_en, r_carry, r_cout, r_ovf, r_busy, r_done;
    logic [IDX_W-1:0]   r_idx;

    op_cfg_t            w_cfg;
    logic               w_accept, w_last, w_cout, w_ovf;
    logic [WIDTH-1:0]   w_op, w_res, w_final;
    logic [SLICE_W-1:0] w_op_sl, w_acc_sl, w_sum;

    assign w_cfg    = '{inv: inv, acc_en: acc_en, cin: cin};
    assign w_op     = r_inv ? ~r_a : r_a;
    assign w_last   = (r_state == RUN) && (r_idx == LAST_IDX);
    assign w_accept = !clr && start && (r_state == IDLE || r_state == DONE);

    // s is frozen during RUN, so it doubles as the pre-operation accumulator snapshot.
    assign w_op_sl  = w_op[int'(r_idx)*SLICE_W +: SLICE_W];
    assign w_acc_sl = r_acc_en ? r_s[int'(r_idx)*SLICE_W +: SLICE_W] : '0;

    adder_slice #(.W(SLICE_W)) u_slice (
        .i_a    (w_op_sl),
        .i_b    (w_acc_sl),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_comb begin
        w_res = r_shadow;
        w_res[int'(r_idx)*SLICE_W +: SLICE_W] = w_sum;
    end

    assign w_ovf   = r_acc_en && (w_op[WIDTH-1] == r_s[WIDTH-1]) && (w_res[WIDTH-1] != w_op[WIDTH-1]);
    assign w_final = (SAT && w_ovf) ? (w_op[WIDTH-1] ? SAT_NEG : SAT_POS) : w_res;

    always_comb begin
        w_next = r_state;
        if (clr) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) w_next = RUN;
                RUN:     if (r_idx == LAST_IDX) w_next = DONE;
                DONE:    w_next = start ? RUN : IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_inv    <= 1'b0;
            r_acc_en <= 1'b0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_shadow <= '0;
            r_s      <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == RUN);
            r_done  <= (w_next == DONE);
            if (clr) begin
                r_s     <= '0;
                r_cout  <= 1'b0;
                r_ovf   <= 1'b0;
                r_idx   <= '0;
                r_carry <= 1'b0;
            end else if (w_accept) begin
                r_a      <= a;
                r_inv    <= w_cfg.inv;
                r_acc_en <= w_cfg.acc_en;
                r_carry  <= w_cfg.acc_en & w_cfg.cin;
                r_idx    <= '0;
                r_shadow <= '0;
            end else if (r_state == RUN) begin
                r_shadow <= w_res;
                r_carry  <= w_cout;
                r_idx    <= r_idx + IDX_W'(1);
                if (w_last) begin
                    r_s    <= w_final;
                    r_cout <= r_acc_en & w_cout;
                    r_ovf  <= w_ovf;
                    r_idx  <= '0;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign s    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_addac_serial.sv
// Scoreboard bench: wrap (SAT=0) and saturating (SAT=1) instances share stimulus.
module tb_addac_serial;

    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rst, start, inv, acc_en, cin, clr;
    logic [15:0] a;
    logic        busy0, done0, cout0, ovf0, busy1, done1, cout1, ovf1;
    logic [15:0] s0, s1;

    always #5 clk = ~clk;

    addac_serial #(.WIDTH(16), .SLICE_W(4), .SAT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .a(a), .inv(inv), .acc_en(acc_en),
        .cin(cin), .clr(clr), .busy(busy0), .done(done0), .s(s0), .cout(cout0), .ovf(ovf0));

    addac_serial #(.WIDTH(16), .SLICE_W(4), .SAT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .inv(inv), .acc_en(acc_en),
        .cin(cin), .clr(clr), .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1));

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    exp_t        q0[$], q1[$];
    exp_t        m0, m1;
    int          checks = 0, passes = 0;
    logic [15:0] acc0 = 16'h0, acc1 = 16'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: signed/unsigned integer arithmetic on the whole word.
    function automatic exp_t model(input logic [15:0] av, input logic iv, input logic ae,
                                   input logic ci, input bit sat, input logic [15:0] acc);
        exp_t        e;
        logic [15:0] op;
        int          sum_u, sum_s;
        op = iv ? ~av : av;
        if (!ae) begin
            e.s = op; e.c = 1'b0; e.o = 1'b0;
            return e;
        end
        sum_u = int'(op) + int'(acc) + int'(ci);
        sum_s = int'($signed(op)) + int'($signed(acc)) + int'(ci);
        e.c = (sum_u >= 65536);
        e.o = (sum_s > 32767) || (sum_s < -32768);
        e.s = 16'(sum_u % 65536);
        if (sat && e.o) e.s = (sum_s > 0) ? 16'h7FFF : 16'h8000;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done0) begin
            if (q0.size() == 0) chk("unexpected_done0", 32'd1, 32'd0);
            else begin
                m0 = q0.pop_front();
                chk("s0", 32'(s0), 32'(m0.s));
                chk("cout0", 32'(cout0), 32'(m0.c));
                chk("ovf0", 32'(ovf0), 32'(m0.o));
            end
        end
        if (done1) begin
            if (q1.size() == 0) chk("unexpected_done1", 32'd1, 32'd0);
            else begin
                m1 = q1.pop_front();
                chk("s1", 32'(s1), 32'(m1.s));
                chk("cout1", 32'(cout1), 32'(m1.c));
                chk("ovf1", 32'(ovf1), 32'(m1.o));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        a = 16'($urandom); inv = 1'($urandom); acc_en = 1'($urandom); cin = 1'($urandom);
    endtask

    // Issues one op and steps to its DONE cycle; poke pulses start mid-RUN.
    task automatic run_op(input logic [15:0] av, input logic iv, input logic ae,
                          input logic ci, input bit poke);
        exp_t        e0, e1;
        logic [15:0] p0, p1;
        e0 = model(av, iv, ae, ci, 1'b0, acc0);
        e1 = model(av, iv, ae, ci, 1'b1, acc1);
        q0.push_back(e0); q1.push_back(e1);
        acc0 = e0.s; acc1 = e1.s;
        p0 = s0; p1 = s1;
        a = av; inv = iv; acc_en = ae; cin = ci; start = 1'b1;
        tick();
        start = 1'b0;
        scramble();
        for (int k = 0; k < NS; k++) begin
            chk("busy_run", 32'({busy0, busy1}), 32'b11);
            chk("done_run", 32'({done0, done1}), 32'b00);
            chk("s_stable", 32'({s0, s1}), 32'({p0, p1}));
            if (poke && k == 1) begin
                start = 1'b1;
                scramble();
            end
            tick();
            start = 1'b0;
        end
        chk("done_latency", 32'({done0, done1, busy0, busy1}), 32'b1100);
    endtask

    task automatic abort_at(input int idx, input bit use_rst);
        a = 16'($urandom); inv = 1'b0; acc_en = 1'b1; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (idx) tick();
        if (use_rst) rst = 1'b1;
        else begin
            clr = 1'b1;
            start = 1'b1;   // dropped: clr wins
        end
        tick();
        rst = 1'b0; clr = 1'b0; start = 1'b0;
        acc0 = 16'h0; acc1 = 16'h0;
        chk(use_rst ? "rst_s" : "clr_s", 32'({s0, s1}), 32'h0);
        chk(use_rst ? "rst_flags" : "clr_flags",
            32'({busy0, busy1, done0, done1, cout0, cout1, ovf0, ovf1}), 32'h0);
        repeat (NS + 2) tick();
        chk("no_done_after_abort", 32'({busy0, busy1, done0, done1}), 32'h0);
    endtask

    initial begin
        logic [15:0] av;
        rst = 1'b1; clr = 1'b0; start = 1'b0; a = 16'h0; inv = 1'b0; acc_en = 1'b0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_s", 32'({s0, s1}), 32'h0);
        chk("reset_flags", 32'({busy0, busy1, done0, done1, cout0, cout1, ovf0, ovf1}), 32'h0);

        run_op(16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        run_op(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(16'h0007, 1'b1, 1'b1, 1'b1, 1'b0);
        run_op(16'h0002, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        run_op(16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(16'h8000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);

        abort_at(2, 1'b0);
        run_op(16'h4321, 1'b0, 1'b1, 1'b1, 1'b1);
        abort_at(1, 1'b1);
        run_op(16'h00A5, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0:       av = 16'h7FFF;
                1:       av = 16'h8000;
                2:       av = 16'hFFFF;
                default: av = 16'($urandom);
            endcase
            run_op(av, 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
                   ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 2) == 0) tick();
        end

        repeat (3) tick();
        chk("queue0_drained", 32'(q0.size()), 32'd0);
        chk("queue1_drained", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
